param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO that succeeds the fixed 8-bit, depth-4 synchronous FIFO.
- Adds generic width and depth, including non-power-of-2 depths.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Defines behaviour for simultaneous read/write at the full and empty boundaries.
- Used as the general buffering element between producer and consumer datapaths in the same clock domain.

Parameters:
WIDTH, 8, data bit width (>=1)
DEPTH, 8, number of entries (>=2; any integer, power of 2 not required)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  write request
data_in  input  WIDTH  write data
rd_en  input  1  read request
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write rejected because FIFO was full
underflow  output  1  sticky: read rejected because FIFO was empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
Reset:
- rst asserts asynchronously, at any time including mid-burst.
- On reset, wr_ptr, rd_ptr and count go to 0; data_out, overflow and underflow go to 0.
- Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Memory contents are not cleared.

Accept rules, evaluated on pre-edge state:
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc).

Boundary cases:
- Full with wr_en and rd_en both high: both accepted; count unchanged; overflow not set.
- Empty with wr_en and rd_en both high: write accepted, read rejected; count becomes 1; underflow set.

Write path:
- On wr_acc: mem[wr_ptr] <= data_in.
- wr_ptr increments, wrapping from DEPTH-1 to 0.

Read path (default build):
- On rd_acc: data_out <= mem[rd_ptr] at that edge, so data is valid the cycle after rd_en is sampled (1-cycle latency).
- rd_ptr wraps from DEPTH-1 to 0.
- data_out holds its value on any cycle without rd_acc, including rejected reads.

Count:
- count <= count + wr_acc - rd_acc.
- Never exceeds DEPTH and never goes below 0.

Flags:
- full, empty, almost_full and almost_empty are decoded from the count register only.
- They are glitch-free and valid immediately after the edge.

Error flags:
- overflow is set when wr_en && full && !rd_en.
- underflow is set when rd_en && empty.
- Both are sticky until err_clr=1 at an edge or rst.
- If err_clr and a new error event occur in the same cycle, the set wins.

Invariants:
- full and empty are never both 1.
- Pointers are equal whenever count==0 or count==DEPTH.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through.
  - data_out = mem[rd_ptr] combinationally whenever !empty; 0 when empty.
  - rd_en acknowledges/pops the displayed word; the next word appears after the edge.
  - Accept, count and flag rules are unchanged.
  - Write-then-read of a single word: data visible on data_out the cycle after the write edge.
- Undefined: registered read with 1-cycle latency, as in Behaviour.

Test Plan:
1. Reset then 8 consecutive writes 0x11..0x18, no reads -> count=8, full=1, almost_full=1 from count=6, overflow=0; 9th write 0x99 -> overflow=1, count stays 8, 0x99 never read out.
2. From full, 8 consecutive reads -> data_out sequence 0x11..0x18, one cycle after each rd_en; empty=1 after 8th; 9th read -> underflow=1, data_out holds 0x18.
3. Fill to 8, then 3 cycles with wr_en=rd_en=1 (data 0xA1..0xA3) -> full stays 1, count=8, overflow=0, reads return 0x11..0x13; 0xA1..0xA3 later emerge after 0x14..0x18.
4. Empty FIFO, wr_en=rd_en=1 with 0x5A -> count=1, underflow=1; next read returns 0x5A; err_clr=1 -> underflow=0.
5. Wrap-around with DEPTH=5: 12 writes interleaved with reads, count never >5 -> output order equals input order; pointers wrap 4->0 with no data loss.
6. Assert rst asynchronously between edges at count=5 -> count=0, empty=1, data_out=0 immediately, without waiting for a clock edge; the next write/read returns the new data only.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky error flags.
// Defining FIFO_FWFT_EN selects first-word-fall-through reads; otherwise reads have 1-cycle registered latency.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Flags decode only the count register, so they are clean right after the edge.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is still accepted when a read frees a slot that same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Clear first so a same-cycle error event overrides err_clr.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full && !rd_en) overflow_d  = 1'b1;
    if (rd_en && empty)          underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (registered-read build): vector table on a depth-8 FIFO,
// plus hand sequences for asynchronous reset and depth-5 wrap-around.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       w5, r5, clr5;
  logic [7:0] d5, q5;
  logic       f5, e5, af5, ae5, ov5, un5;
  logic [2:0] c5;

  param_sync_fifo #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .wr_en(w5), .data_in(d5), .rd_en(r5),
    .data_out(q5), .full(f5), .empty(e5), .almost_full(af5),
    .almost_empty(ae5), .count(c5), .overflow(ov5),
    .underflow(un5), .err_clr(clr5)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    logic [7:0] dout;
    int         cnt;
    logic       ov, un;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [7:0] din,
                     input logic [7:0] dout, input int cnt, input logic ov, input logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.dout = dout; v.cnt = cnt; v.ov = ov; v.un = un;
    tv.push_back(v);
  endtask

  // Depth 8, AF_LEVEL 6, AE_LEVEL 2: flags follow from the expected occupancy.
  task automatic chk(input string nm, input logic [7:0] ed, input int ec, input logic eov, input logic eun);
    logic [17:0] got, exp;
    logic ef, ee, eaf, eae;
    ef  = (ec == 8);
    ee  = (ec == 0);
    eaf = (ec >= 6);
    eae = (ec <= 2);
    got = {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};
    exp = {ed, 4'(ec), ef, ee, eaf, eae, eov, eun};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got dout=%h cnt=%0d f/e/af/ae/ov/un=%b%b%b%b%b%b, want dout=%h cnt=%0d f/e/af/ae/ov/un=%b%b%b%b%b%b",
               nm, data_out, count, full, empty, almost_full, almost_empty, overflow, underflow,
               ed, ec, ef, ee, eaf, eae, eov, eun);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
    @(negedge clk);
    wr_en = wr; rd_en = rd; err_clr = clr; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte unsigned q[$];
    logic [7:0]   exp5;
    logic         racc, wacc;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
    w5 = 1'b0; r5 = 1'b0; clr5 = 1'b0; d5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow, clear
    for (int k = 0; k < 8; k++) add(1, 0, 0, 8'(8'h11 + k), 8'h00, k + 1, 0, 0);
    add(1, 0, 0, 8'h99, 8'h00, 8, 1, 0);
    add(0, 0, 1, 8'h00, 8'h00, 8, 0, 0);
    // Drain, underflow holds data_out, clear
    for (int k = 0; k < 8; k++) add(0, 1, 0, 8'h00, 8'(8'h11 + k), 7 - k, 0, 0);
    add(0, 1, 0, 8'h00, 8'h18, 0, 0, 1);
    add(0, 0, 1, 8'h00, 8'h18, 0, 0, 0);
    // Refill, then simultaneous read/write at full
    for (int k = 0; k < 8; k++) add(1, 0, 0, 8'(8'h11 + k), 8'h18, k + 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 8'(8'hA1 + k), 8'(8'h11 + k), 8, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h00, 8'(8'h14 + k), 7 - k, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 8'h00, 8'(8'hA1 + k), 2 - k, 0, 0);
    // Simultaneous read/write at empty, then set-beats-clear
    add(1, 1, 0, 8'h5A, 8'hA3, 1, 0, 1);
    add(0, 1, 0, 8'h00, 8'h5A, 0, 0, 1);
    add(0, 0, 1, 8'h00, 8'h5A, 0, 0, 0);
    add(0, 1, 1, 8'h00, 8'h5A, 0, 0, 1);
    add(0, 0, 1, 8'h00, 8'h5A, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din);
      chk($sformatf("vec%0d", i), tv[i].dout, tv[i].cnt, tv[i].ov, tv[i].un);
    end

    // Asynchronous reset between edges with occupancy 5
    for (int k = 0; k < 6; k++) step(1, 0, 0, 8'(8'h21 + k));
    step(0, 1, 0, 8'h00);
    chk("pre_rst", 8'h21, 5, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #3 rst = 1'b1;
    #1 chk("async_rst", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 8'h77);
    chk("post_rst_wr", 8'h00, 1, 1'b0, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("post_rst_rd", 8'h77, 0, 1'b0, 1'b0);
    step(0, 0, 0, 8'h00);

    // Depth-5 wrap-around against an ordered queue
    exp5 = 8'h00;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      w5 = (c < 12); r5 = (c >= 5); d5 = 8'(8'h30 + c);
      racc = r5 && (q.size() > 0);
      wacc = w5 && ((q.size() < 5) || racc);
      if (racc) exp5 = q.pop_front();
      if (wacc) q.push_back(d5);
      @(posedge clk);
      #1;
      n_vec++;
      if (q5 !== exp5 || int'(c5) != q.size() || f5 !== (q.size() == 5) ||
          e5 !== (q.size() == 0) || ov5 !== 1'b0 || un5 !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap5_c%0d: got dout=%h cnt=%0d f=%b e=%b ov=%b un=%b, want dout=%h cnt=%0d f=%b e=%b ov=0 un=0",
                 c, q5, c5, f5, e5, ov5, un5, exp5, q.size(), (q.size() == 5), (q.size() == 0));
      end
    end
    @(negedge clk);
    w5 = 1'b0; r5 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
